// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size/state encodings and byte-lane helpers for the memory access controller
package mem_access_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] off);
    return size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    return size == SZ_ILL || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: replicates store data across lanes and shifts/extends load data
module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata_ext = size == SZ_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
                size == SZ_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side load/store controller for a 32-word byte-enabled RAM
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [CNT_W-1:0]  ld_cnt,
  output logic [CNT_W-1:0]  st_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  state_e      state, state_nx;
  size_e       r_size, al_size;
  logic        r_wr, r_sgn, accept, done, err_in;
  logic [1:0]  r_off, al_off;
  logic [3:0]  r_wen;
  logic [31:0] wdata_rep, rdata_ext;
  assign accept     = req_valid && req_ready;
  assign done       = resp_valid && resp_ready;
  assign err_in     = misaligned(size_e'(req_size), req_addr[1:0]);
  assign req_ready  = resetn && state == ST_IDLE;
  assign resp_valid = state == ST_RESP;
  // Combinational from state so an async reset kills the write strobe at once
  assign ram_wen    = state == ST_ACCESS && r_wr ? r_wen : 4'b0000;
  // One aligner serves both paths: request fields in IDLE, captured fields in ACCESS
  assign al_size    = state == ST_IDLE ? size_e'(req_size) : r_size;
  assign al_off     = state == ST_IDLE ? req_addr[1:0] : r_off;
  mem_lane_align u_align (
    .size      (al_size),
    .off       (al_off),
    .sgn       (r_sgn),
    .wdata     (req_wdata),
    .rdata     (ram_rdata),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == ST_IDLE   ? (accept ? (err_in ? ST_RESP : ST_ACCESS) : ST_IDLE) :
               state == ST_ACCESS ? ST_RESP : (done ? ST_IDLE : ST_RESP);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_wr       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_sgn      <= 1'b0;
      r_off      <= 2'b00;
      r_wen      <= 4'b0000;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ld_cnt     <= '0;
      st_cnt     <= '0;
      err_cnt    <= '0;
    end else begin
      if (accept) begin
        r_wr       <= req_wr;
        r_size     <= size_e'(req_size);
        r_sgn      <= req_signed;
        r_off      <= req_addr[1:0];
        r_wen      <= byte_en(size_e'(req_size), req_addr[1:0]);
        resp_err   <= err_in;
        resp_rdata <= '0;
        if (!err_in) ram_addr <= req_addr[ADDR_W-1:2];
        if (!err_in && req_wr) ram_wdata <= wdata_rep;
      end
      if (state == ST_ACCESS && !r_wr) resp_rdata <= rdata_ext;
      if (done) begin
        if (resp_err) err_cnt <= err_cnt + CNT_W'(1);
        else if (r_wr) st_cnt <= st_cnt + CNT_W'(1);
        else ld_cnt <= ld_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks against a byte-level memory model
module tb_mem_access_ctrl;
  logic clk = 1'b0, resetn = 1'b0;
  logic req_valid = 1'b0, req_wr = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [6:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_wen;
  logic [4:0] ram_addr;
  logic [15:0] ld_cnt, st_cnt, err_cnt;
  logic [31:0] mem [32] = '{default: 32'h0};
  logic [31:0] ref_mem [32] = '{default: 32'h0};
  int checks = 0, errors = 0;
  int exp_ld = 0, exp_st = 0, exp_err = 0;
  logic [31:0] o_rd, o_wd;
  logic o_er;
  logic [3:0] o_wen;
  logic [4:0] o_addr;
  int o_lat, o_nwr;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(7), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ld_cnt(ld_cnt), .st_cnt(st_cnt),
    .err_cnt(err_cnt)
  );

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (ram_wen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];

  function automatic logic is_err(input logic [1:0] sz, input logic [6:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg, input logic [6:0] a);
    logic [31:0] w, v;
    int nb;
    w = ref_mem[a[6:2]];
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(a[1:0] + i) +: 8];
    if (sg && nb < 4 && v[8*nb-1]) for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic apply_store(input logic [1:0] sz, input logic [6:0] a, input logic [31:0] wd);
    int nb;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    for (int i = 0; i < nb; i++) ref_mem[a[6:2]][8*(a[1:0] + i) +: 8] = wd[8*i +: 8];
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [6:0] a, input logic [31:0] wd);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    req_valid = 1'b0;
    o_lat = 1; o_nwr = 0; o_wen = 4'h0; o_wd = 32'h0; o_addr = ram_addr;
    while (!resp_valid && o_lat < 20) begin
      if (ram_wen != 4'h0) begin o_nwr++; o_wen = ram_wen; o_wd = ram_wdata; end
      @(negedge clk);
      o_lat++;
    end
    if (ram_wen != 4'h0) o_nwr++;
    o_rd = resp_rdata; o_er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    if (is_err(sz, a)) exp_err++;
    else if (wr) begin exp_st++; apply_store(sz, a, wd); end
    else exp_ld++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ram_wen !== 4'h0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl wen=%h ready=%b valid=%b want 0 0 0", ram_wen, req_ready, resp_valid);
    end
    checks++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || ram_addr !== 5'h0 || ram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data rdata=%h err=%b addr=%h wdata=%h want zeros", resp_rdata, resp_err, ram_addr, ram_wdata);
    end
    checks++;
    if (ld_cnt !== 16'h0 || st_cnt !== 16'h0 || err_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt ld=%0d st=%0d err=%0d want 0", ld_cnt, st_cnt, err_cnt);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release ready=%b want 1", req_ready); end
  endtask

  task automatic test_word();
    do_req(1'b1, 2'd2, 1'b0, 7'h08, 32'h12345678);
    checks++;
    if (o_nwr !== 1 || o_wen !== 4'hF || o_addr !== 5'd2 || o_wd !== 32'h12345678) begin
      errors++; $display("FAIL word_store nwr=%0d wen=%h addr=%0d wd=%h want 1 f 2 12345678", o_nwr, o_wen, o_addr, o_wd);
    end
    checks++;
    if (o_lat !== 2 || o_er !== 1'b0 || o_rd !== 32'h0) begin
      errors++; $display("FAIL word_store_resp lat=%0d err=%b rd=%h want 2 0 0", o_lat, o_er, o_rd);
    end
    do_req(1'b0, 2'd2, 1'b1, 7'h08, 32'h0);
    checks++;
    if (o_rd !== exp_load(2'd2, 1'b1, 7'h08) || o_er !== 1'b0 || o_lat !== 2 || o_nwr !== 0) begin
      errors++; $display("FAIL word_load rd=%h err=%b lat=%0d nwr=%0d want %h 0 2 0", o_rd, o_er, o_lat, o_nwr, exp_load(2'd2, 1'b1, 7'h08));
    end
  endtask

  task automatic test_byte_merge();
    do_req(1'b1, 2'd2, 1'b0, 7'h0C, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 7'h0D, 32'h000000AB);
    checks++;
    if (o_wen !== 4'b0010 || o_wd !== 32'hABABABAB || o_nwr !== 1) begin
      errors++; $display("FAIL byte_store wen=%b wd=%h nwr=%0d want 0010 abababab 1", o_wen, o_wd, o_nwr);
    end
    do_req(1'b0, 2'd2, 1'b0, 7'h0C, 32'h0);
    checks++;
    if (o_rd !== exp_load(2'd2, 1'b0, 7'h0C)) begin
      errors++; $display("FAIL byte_merge rd=%h want %h", o_rd, exp_load(2'd2, 1'b0, 7'h0C));
    end
  endtask

  task automatic test_half();
    do_req(1'b1, 2'd1, 1'b0, 7'h12, 32'h55558001);
    checks++;
    if (o_wen !== 4'b1100 || o_wd !== 32'h80018001) begin
      errors++; $display("FAIL half_store wen=%b wd=%h want 1100 80018001", o_wen, o_wd);
    end
    do_req(1'b0, 2'd1, 1'b1, 7'h12, 32'h0);
    checks++;
    if (o_rd !== exp_load(2'd1, 1'b1, 7'h12)) begin
      errors++; $display("FAIL half_signed rd=%h want %h", o_rd, exp_load(2'd1, 1'b1, 7'h12));
    end
    do_req(1'b0, 2'd1, 1'b0, 7'h12, 32'h0);
    checks++;
    if (o_rd !== exp_load(2'd1, 1'b0, 7'h12)) begin
      errors++; $display("FAIL half_unsigned rd=%h want %h", o_rd, exp_load(2'd1, 1'b0, 7'h12));
    end
    do_req(1'b0, 2'd0, 1'b1, 7'h13, 32'h0);
    checks++;
    if (o_rd !== exp_load(2'd0, 1'b1, 7'h13)) begin
      errors++; $display("FAIL byte_signed rd=%h want %h", o_rd, exp_load(2'd0, 1'b1, 7'h13));
    end
  endtask

  task automatic test_errors();
    logic [1:0] sz [3] = '{2'd2, 2'd1, 2'd3};
    logic [6:0] ad [3] = '{7'h05, 7'h03, 7'h20};
    for (int i = 0; i < 3; i++) begin
      do_req(i[0], sz[i], 1'b1, ad[i], 32'hFFFFFFFF);
      checks++;
      if (o_er !== 1'b1 || o_rd !== 32'h0 || o_lat !== 1 || o_nwr !== 0) begin
        errors++; $display("FAIL err_req%0d err=%b rd=%h lat=%0d nwr=%0d want 1 0 1 0", i, o_er, o_rd, o_lat, o_nwr);
      end
    end
    checks++;
    if (err_cnt !== 16'(exp_err)) begin errors++; $display("FAIL err_cnt got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_backpressure();
    logic [31:0] first, exp;
    int lat;
    exp = exp_load(2'd2, 1'b0, 7'h0C);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 7'h0C;
    @(negedge clk);
    req_wr = 1'b1; req_addr = 7'h40; req_wdata = 32'hCAFEF00D;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    first = resp_rdata;
    checks++;
    if (lat !== 2 || first !== exp) begin
      errors++; $display("FAIL bp_resp lat=%0d rd=%h want 2 %h", lat, first, exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d valid=%b rd=%h ready=%b want 1 %h 0", i, resp_valid, resp_rdata, req_ready, first);
      end
    end
    checks++;
    if (mem[16] !== ref_mem[16]) begin errors++; $display("FAIL bp_no_accept mem16=%h want %h", mem[16], ref_mem[16]); end
    resp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_ld++;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ld_cnt !== 16'(exp_ld)) begin
      errors++; $display("FAIL bp_release ready=%b valid=%b ld=%0d want 1 0 %0d", req_ready, resp_valid, ld_cnt, exp_ld);
    end
  endtask

  task automatic test_random();
    logic wr, sg;
    logic [1:0] sz;
    logic [6:0] a;
    logic [31:0] wd, exp;
    logic e;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom); a = 7'($urandom); wd = $urandom;
      e = is_err(sz, a);
      exp = (e || wr) ? 32'h0 : exp_load(sz, sg, a);
      do_req(wr, sz, sg, a, wd);
      checks++;
      if (o_er !== e || o_rd !== exp || o_lat !== (e ? 1 : 2) || o_nwr !== ((wr && !e) ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d wr=%b sz=%0d a=%h err=%b rd=%h lat=%0d nwr=%0d want %b %h %0d %0d",
                           n, wr, sz, a, o_er, o_rd, o_lat, o_nwr, e, exp, e ? 1 : 2, (wr && !e) ? 1 : 0);
      end
      checks++;
      if (ld_cnt !== 16'(exp_ld) || st_cnt !== 16'(exp_st) || err_cnt !== 16'(exp_err)) begin
        errors++; $display("FAIL rand_cnt%0d ld=%0d st=%0d err=%0d want %0d %0d %0d", n, ld_cnt, st_cnt, err_cnt, exp_ld, exp_st, exp_err);
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL ram_word%0d got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_addr = 7'h10; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (ram_wen !== 4'hF) begin errors++; $display("FAIL rst_access_wen got %h want f", ram_wen); end
    resetn = 1'b0;
    #1;
    checks++;
    if (ram_wen !== 4'h0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_async wen=%h ready=%b want 0 0", ram_wen, req_ready);
    end
    @(negedge clk);
    exp_ld = 0; exp_st = 0; exp_err = 0;
    checks++;
    if (mem[4] !== ref_mem[4]) begin errors++; $display("FAIL rst_word4 got %h want %h", mem[4], ref_mem[4]); end
    checks++;
    if (ld_cnt !== 16'h0 || st_cnt !== 16'h0 || err_cnt !== 16'h0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_state ld=%0d st=%0d err=%0d valid=%b want 0 0 0 0", ld_cnt, st_cnt, err_cnt, resp_valid);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_merge();
    test_half();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
